// File: rtl/om_dcr_write_arbiter.sv
// Purpose: round-robin arbiter sharing the OM DCR write bus between NUM_REQS sources, with locked multi-beat bursts.
// Latency: one cycle from an accepted beat (req_ready high) to dcr_write_valid; one write per cycle sustained.
// Backpressure: req_ready is combinational; withheld from all sources while om_busy or reset, and from non-owners while locked.
module om_dcr_write_arbiter #(
    parameter  int NUM_REQS  = 4,
    parameter  int ADDR_BITS = 12,
    parameter  int DATA_BITS = 32,
    localparam int IDX_BITS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           req_valid,
    input  logic [NUM_REQS*ADDR_BITS-1:0] req_addr,
    input  logic [NUM_REQS*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQS-1:0]           req_last,
    output logic [NUM_REQS-1:0]           req_ready,
    input  logic                          om_busy,
    output logic                          dcr_write_valid,
    output logic [ADDR_BITS-1:0]          dcr_write_addr,
    output logic [DATA_BITS-1:0]          dcr_write_data,
    output logic [IDX_BITS-1:0]           grant_idx,
    output logic                          locked
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [IDX_BITS:0] NUM_W = (IDX_BITS + 1)'(NUM_REQS);

    state_t                              state_q, state_d;
    logic [IDX_BITS-1:0]                 owner_q, owner_d;
    logic [IDX_BITS-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [IDX_BITS-1:0]                 win_idx;
    logic [IDX_BITS-1:0]                 sel_idx;
    logic [IDX_BITS:0]                   scan_pos;
    logic                                win_found;
    logic                                accept;
    logic [NUM_REQS-1:0][ADDR_BITS-1:0]  addr_arr;
    logic [NUM_REQS-1:0][DATA_BITS-1:0]  data_arr;

    assign addr_arr = req_addr;
    assign data_arr = req_data;

    // Next round-robin position after source i, wrapping at NUM_REQS.
    function automatic logic [IDX_BITS-1:0] wrap_inc(input logic [IDX_BITS-1:0] i);
        logic [IDX_BITS:0] s;
        s = {1'b0, i} + (IDX_BITS + 1)'(1);
        if (s >= NUM_W) begin
            s = '0;
        end
        return s[IDX_BITS-1:0];
    endfunction

    // First valid source scanning upward from rr_ptr, modulo NUM_REQS.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_pos  = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            scan_pos = {1'b0, rr_ptr_q} + (IDX_BITS + 1)'(k);
            if (scan_pos >= NUM_W) begin
                scan_pos = scan_pos - NUM_W;
            end
            if (!win_found && req_valid[scan_pos[IDX_BITS-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_pos[IDX_BITS-1:0];
            end
        end
    end

    // Grant selection, lock entry/exit and round-robin pointer update.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        req_ready = '0;
        sel_idx   = owner_q;
        if (!reset && !om_busy) begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        sel_idx            = win_idx;
                        req_ready[win_idx] = 1'b1;
                        if (req_last[win_idx]) begin
                            rr_ptr_d = wrap_inc(win_idx);
                        end else begin
                            state_d = LOCKED;
                            owner_d = win_idx;
                        end
                    end
                end
                LOCKED: begin
                    // Owner may pause mid-burst; the lock is held until its last beat.
                    if (req_valid[owner_q]) begin
                        req_ready[owner_q] = 1'b1;
                        if (req_last[owner_q]) begin
                            state_d  = IDLE;
                            rr_ptr_d = wrap_inc(owner_q);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign accept = |req_ready;
    assign locked = (state_q == LOCKED);

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Output stage: register the accepted beat; addr/data/grant hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            dcr_write_valid <= 1'b0;
            dcr_write_addr  <= '0;
            dcr_write_data  <= '0;
            grant_idx       <= '0;
        end else begin
            dcr_write_valid <= accept;
            if (accept) begin
                dcr_write_addr <= addr_arr[sel_idx];
                dcr_write_data <= data_arr[sel_idx];
                grant_idx      <= sel_idx;
            end
        end
    end

    // Sources must hold a pending request unchanged until it is accepted.
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_hold_chk
        a_req_stable: assert property (@(posedge clk) disable iff (reset)
            (req_valid[i] && !req_ready[i]) |=>
                (req_valid[i] && $stable(addr_arr[i]) && $stable(data_arr[i]) && $stable(req_last[i])));
    end

endmodule

// File: tb/tb_om_dcr_write_arbiter.sv
// Purpose: self-checking bench for om_dcr_write_arbiter (4 sources, 12-bit addr, 32-bit data).
// Latency: expected beats are queued at the cycle they are accepted and must appear on dcr_write_* one cycle later.
// Backpressure: sources hold requests until ready; om_busy and locks are driven to exercise withheld ready.
module tb_om_dcr_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int IW = 2;

    localparam logic [AW-1:0] STENCIL_FUNC  = 12'h0A0;
    localparam logic [AW-1:0] STENCIL_ZPASS = 12'h0A1;
    localparam logic [AW-1:0] STENCIL_ZFAIL = 12'h0A2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            om_busy;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            dcr_write_valid;
    logic [AW-1:0]   dcr_write_addr;
    logic [DW-1:0]   dcr_write_data;
    logic [IW-1:0]   grant_idx;
    logic            locked;

    logic [AW-1:0]   src_addr [N];
    logic [DW-1:0]   src_data [N];

    exp_t            exp_q [$];
    exp_t            mon_e;
    int              tests_run    = 0;
    int              tests_failed = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = src_addr[i];
            req_data[i*DW +: DW] = src_data[i];
        end
    end

    om_dcr_write_arbiter #(
        .NUM_REQS  (N),
        .ADDR_BITS (AW),
        .DATA_BITS (DW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .om_busy         (om_busy),
        .dcr_write_valid (dcr_write_valid),
        .dcr_write_addr  (dcr_write_addr),
        .dcr_write_data  (dcr_write_data),
        .grant_idx       (grant_idx),
        .locked          (locked)
    );

    // Scoreboard: every cycle, the output stage must carry exactly the beat queued the cycle before.
    always begin
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            tests_run++;
            if (dcr_write_valid !== 1'b1 || dcr_write_addr !== mon_e.addr ||
                dcr_write_data !== mon_e.data || grant_idx !== mon_e.idx) begin
                tests_failed++;
                $display("FAIL write_beat: got v=%b a=%h d=%h g=%0d want v=1 a=%h d=%h g=%0d",
                         dcr_write_valid, dcr_write_addr, dcr_write_data, grant_idx,
                         mon_e.addr, mon_e.data, mon_e.idx);
            end
        end else if (!reset) begin
            tests_run++;
            if (dcr_write_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL unexpected_write: got v=%b a=%h g=%0d want v=0",
                         dcr_write_valid, dcr_write_addr, grant_idx);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_exp(input int s);
        exp_t e;
        e.addr = src_addr[s];
        e.data = src_data[s];
        e.idx  = IW'(s);
        exp_q.push_back(e);
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        om_busy   = 1'b0;
        req_valid = 4'hF;
        req_last  = 4'hF;
        for (int i = 0; i < N; i++) begin
            src_addr[i] = 12'h100 + AW'(i);
            src_data[i] = 32'hDEAD_0000 + DW'(i);
        end
        step();
        step();
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        tests_run++;
        if (dcr_write_valid !== 1'b0 || locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid_locked: got v=%b l=%b want v=0 l=0", dcr_write_valid, locked);
        end
        tests_run++;
        if (dcr_write_addr !== 12'h0 || dcr_write_data !== 32'h0 || grant_idx !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got a=%h d=%h g=%0d want 0/0/0", dcr_write_addr, dcr_write_data, grant_idx);
        end
        step();
        reset     = 1'b0;
        req_valid = 4'h0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        for (int i = 0; i < N; i++) begin
            src_addr[i] = 12'h010 + AW'(i);
            src_data[i] = 32'h1000 + DW'(i);
        end
        req_last  = 4'hF;
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            want = 4'b0001 << (k % 4);
            @(negedge clk);
            tests_run++;
            if (req_ready !== want) begin
                tests_failed++;
                $display("FAIL rr_grant_%0d: got %b want %b", k, req_ready, want);
            end
            push_exp(k % 4);
            step();
            if (k < 4) src_data[k % 4] = 32'h2000 + DW'(k);
            else       req_valid[k % 4] = 1'b0;
        end
    endtask

    task automatic test_single_write();
        src_addr[1]  = 12'h00A;
        src_data[1]  = 32'h3;
        req_last[1]  = 1'b1;
        req_valid    = 4'b0010;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL single_ready: got %b want 0010", req_ready);
        end
        push_exp(1);
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        tests_run++;
        if (dcr_write_valid !== 1'b1 || dcr_write_addr !== 12'h00A ||
            dcr_write_data !== 32'h3 || grant_idx !== 2'd1) begin
            tests_failed++;
            $display("FAIL single_output: got v=%b a=%h d=%h g=%0d want v=1 a=00a d=3 g=1",
                     dcr_write_valid, dcr_write_addr, dcr_write_data, grant_idx);
        end
        step();
    endtask

    task automatic test_locked_burst();
        logic [N-1:0] want_rdy [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
        logic         want_lck [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int           src_of   [5] = '{2, 2, 2, 3, 0};
        src_addr[0] = 12'h020; src_data[0] = 32'h20; req_last[0] = 1'b1;
        src_addr[3] = 12'h030; src_data[3] = 32'h30; req_last[3] = 1'b1;
        src_addr[2] = STENCIL_FUNC; src_data[2] = 32'h7; req_last[2] = 1'b0;
        req_valid   = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests_run++;
            if (req_ready !== want_rdy[k]) begin
                tests_failed++;
                $display("FAIL burst_ready_%0d: got %b want %b", k, req_ready, want_rdy[k]);
            end
            tests_run++;
            if (locked !== want_lck[k]) begin
                tests_failed++;
                $display("FAIL burst_locked_%0d: got %b want %b", k, locked, want_lck[k]);
            end
            push_exp(src_of[k]);
            step();
            case (k)
                0: begin src_addr[2] = STENCIL_ZPASS; src_data[2] = 32'h2; end
                1: begin src_addr[2] = STENCIL_ZFAIL; src_data[2] = 32'h1; req_last[2] = 1'b1; end
                2: req_valid[2] = 1'b0;
                3: req_valid[3] = 1'b0;
                default: req_valid[0] = 1'b0;
            endcase
        end
    endtask

    task automatic test_busy_stall();
        src_addr[0] = 12'h040; src_data[0] = 32'hB0; req_last[0] = 1'b1;
        om_busy     = 1'b1;
        req_valid   = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tests_run++;
            if (req_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL busy_ready_%0d: got %b want 0000", k, req_ready);
            end
            step();
        end
        om_busy = 1'b0;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL busy_release: got %b want 0001", req_ready);
        end
        push_exp(0);
        step();
        req_valid = 4'b0000;
        // A beat already registered survives om_busy rising.
        src_addr[2] = 12'h050; src_data[2] = 32'hC2; req_last[2] = 1'b1;
        req_valid   = 4'b0100;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL busy_pre_accept: got %b want 0100", req_ready);
        end
        push_exp(2);
        step();
        om_busy   = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        tests_run++;
        if (dcr_write_valid !== 1'b1 || grant_idx !== 2'd2) begin
            tests_failed++;
            $display("FAIL busy_no_cancel: got v=%b g=%0d want v=1 g=2", dcr_write_valid, grant_idx);
        end
        step();
        om_busy = 1'b0;
    endtask

    task automatic test_lock_gap();
        src_addr[0] = 12'h070; src_data[0] = 32'h70; req_last[0] = 1'b1;
        req_valid   = 4'b0001;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL gap_pre: got %b want 0001", req_ready);
        end
        push_exp(0);
        step();
        src_data[0] = 32'h71;
        src_addr[1] = 12'h060; src_data[1] = 32'h60; req_last[1] = 1'b0;
        req_valid   = 4'b0011;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL gap_first: got %b want 0010", req_ready);
        end
        push_exp(1);
        step();
        req_valid[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (req_ready !== 4'b0000 || locked !== 1'b1) begin
                tests_failed++;
                $display("FAIL gap_hold_%0d: got rdy=%b l=%b want rdy=0000 l=1", k, req_ready, locked);
            end
            step();
        end
        src_data[1] = 32'h61; req_last[1] = 1'b1; req_valid[1] = 1'b1;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL gap_last: got %b want 0010", req_ready);
        end
        push_exp(1);
        step();
        req_valid[1] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0001 || locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap_release: got rdy=%b l=%b want rdy=0001 l=0", req_ready, locked);
        end
        push_exp(0);
        step();
        req_valid[0] = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        src_addr[2] = 12'h080; src_data[2] = 32'h80; req_last[2] = 1'b0;
        req_valid   = 4'b0100;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL rst_burst_first: got %b want 0100", req_ready);
        end
        push_exp(2);
        step();
        reset       = 1'b1;
        src_addr[2] = 12'h081; src_data[2] = 32'h81;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0000 || locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_during: got rdy=%b l=%b want rdy=0000 l=1", req_ready, locked);
        end
        step();
        reset     = 1'b0;
        req_valid = 4'b0000;
        @(negedge clk);
        tests_run++;
        if (locked !== 1'b0 || dcr_write_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_after: got l=%b v=%b want l=0 v=0", locked, dcr_write_valid);
        end
        step();
        src_addr[0] = 12'h090; src_data[0] = 32'h90; req_last[0] = 1'b1;
        src_addr[3] = 12'h093; src_data[3] = 32'h93; req_last[3] = 1'b1;
        req_valid   = 4'b1001;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rst_rr_origin: got %b want 0001", req_ready);
        end
        push_exp(0);
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b1000) begin
            tests_failed++;
            $display("FAIL rst_src3: got %b want 1000", req_ready);
        end
        push_exp(3);
        step();
        req_valid[3] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_write();
        test_locked_burst();
        test_busy_stall();
        test_lock_gap();
        test_reset_mid_burst();
        step();
        step();
        #5;
        tests_run++;
        if (exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending beats want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/om_dcr_write_arbiter.md
Name: om_dcr_write_arbiter

Overview:
- Shares the single OM DCR write bus between NUM_REQS independent configuration sources, for example the host DCR path and per-cluster command processors.
- Round-robin arbitration with locked multi-beat bursts. A source can update dependent registers back-to-back without interleaving. Example: STENCIL_FUNC/ZPASS/ZFAIL, whose combined values derive stencil_enable.
- Holds off all writes while the OM pipeline reports busy, so DCR state never changes under in-flight fragments.
- Output drives the OM DCR slave's write_valid/write_addr/write_data.

Parameters:
NUM_REQS, 4, number of requesting sources (≥1); index width IDX_BITS = max(1, clog2(NUM_REQS))
ADDR_BITS, 12, DCR address width
DATA_BITS, 32, DCR data width

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
req_valid  input  NUM_REQS  per-source write request
req_addr  input  NUM_REQS*ADDR_BITS  per-source DCR address, source i at [i*ADDR_BITS +: ADDR_BITS]
req_data  input  NUM_REQS*DATA_BITS  per-source DCR data, same packing
req_last  input  NUM_REQS  1 = final beat of a burst (single writes drive 1)
req_ready  output  NUM_REQS  beat accepted this cycle (one-hot or zero)
om_busy  input  1  OM pipeline has fragments in flight; blocks acceptance
dcr_write_valid  output  1  registered write strobe to OM DCR slave
dcr_write_addr  output  ADDR_BITS  registered write address
dcr_write_data  output  DATA_BITS  registered write data
grant_idx  output  IDX_BITS  source index of the beat currently on dcr_write_*
locked  output  1  1 while state = LOCKED

Behaviour:
- States: IDLE and LOCKED(owner). Registers: state, owner, rr_ptr, the output stage.
- Reset values:
  - state = IDLE, rr_ptr = 0, owner = 0.
  - dcr_write_valid = 0, dcr_write_addr = 0, dcr_write_data = 0, grant_idx = 0, locked = 0.
  - req_ready is combinational and therefore 0 during reset.
- Acceptance is blocked when om_busy = 1 or reset = 1: all req_ready = 0, in either state.
- IDLE, om_busy = 0:
  - Winner g is the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … modulo NUM_REQS.
  - req_ready[g] = 1 in the same cycle (combinational; it may depend on req_valid, and a source must not wait for ready before asserting valid).
  - If req_last[g] = 0: next state = LOCKED, owner = g, rr_ptr unchanged.
  - If req_last[g] = 1: state stays IDLE, rr_ptr = (g+1) mod NUM_REQS.
- LOCKED, om_busy = 0:
  - Only owner is eligible. req_ready[owner] = req_valid[owner]; all other sources see ready 0 even if valid.
  - An accepted beat with req_last = 1 moves to IDLE and sets rr_ptr = (owner+1) mod NUM_REQS.
  - Owner deasserting valid mid-burst keeps the lock, with no timeout.
- Output stage, one-cycle latency:
  - On an accepted beat, the next cycle shows dcr_write_valid = 1, addr/data of that beat, and grant_idx = g.
  - Otherwise dcr_write_valid = 0. addr/data/grant_idx hold their last values.
- Throughput is one write per cycle. Back-to-back beats from the same or different sources produce consecutive valid cycles.
- om_busy rising does not cancel a beat already registered in the output stage. That beat still appears the next cycle.
- NUM_REQS = 1: arbitration degenerates; grant_idx is constant 0; lock behaviour still applies.
- Reset mid-burst: state returns to IDLE and the output valid clears. A beat registered before reset is dropped and the source must replay.
- A request is held stable (valid, addr, data, last) until ready. This is a source obligation, checked by assertion in simulation.

Test Plan:
- Single write: src1 valid addr=0x00A data=0x3 last=1 → ready[1] same cycle; next cycle dcr_write_valid=1, addr=0x00A, data=0x3, grant_idx=1; rr_ptr=2.
- Round-robin: all 4 sources valid, last=1, held continuously → grants 0,1,2,3,0 on consecutive cycles; dcr_write_valid high for 5 consecutive cycles.
- Locked burst:
  - Stimulus: src2 sends 3 beats (last=0,0,1) to STENCIL_FUNC/ZPASS/ZFAIL while src0 and src3 stay valid.
  - Response: output shows the 3 src2 beats contiguously; locked=1 for 2 cycles after beat 1; next grant is src3.
- Busy stall: om_busy=1 for 6 cycles with src0 valid → req_ready=0 and no dcr_write_valid for 6 cycles; om_busy falls → src0 accepted that cycle, written the next.
- Lock with gap: src1 beat last=0, valid low 3 cycles, src0 valid throughout, then src1 beat last=1 → src0 receives no ready until after src1's last beat.
- Reset mid-burst: reset during LOCKED with a beat in the output stage → next cycle locked=0, dcr_write_valid=0, rr_ptr=0; first post-reset request from src3 granted normally.
